vdp_super_res_mixer: RTL and testbench

- Output stage directly downstream of the super-res pixel fetch stage; takes its 8-bit RGB and the legacy V9958 RGB and selects the final pixel per clock.
- Switches the source only at a frame boundary, blanks outside active video, provides a built-in colour-bar test pattern, and delays sync/DE so they stay aligned with the registered RGB.
- Feeds the HDMI/DVI encoder.

---
 rtl/custom_timings_pkg.sv | 31 +++
 rtl/vdp_super_res_mixer_bars.sv | 46 ++++
 rtl/vdp_super_res_mixer.sv | 124 ++++++++++++
 tb/tb_vdp_super_res_mixer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/custom_timings_pkg.sv
// custom_timings: shared video timing constants and pixel types.
//   FRAME_WIDTH/FRAME_HEIGHT per geometry (NTSC 858x525, PAL 864x625),
//   rgb24_t pixel struct and the 8-entry colour-bar table.
package custom_timings;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    localparam logic [10:0] FRAME_WIDTH_NTSC  = 11'd858;
    localparam logic [10:0] FRAME_WIDTH_PAL   = 11'd864;
    localparam logic [9:0]  FRAME_HEIGHT_NTSC = 10'd525;
    localparam logic [9:0]  FRAME_HEIGHT_PAL  = 10'd625;

    // White, yellow, cyan, green, magenta, red, blue, black.
    localparam rgb24_t BAR_COLOURS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic logic [10:0] frame_width(input logic pal);
        return pal ? FRAME_WIDTH_PAL : FRAME_WIDTH_NTSC;
    endfunction

    function automatic logic [9:0] frame_height(input logic pal);
        return pal ? FRAME_HEIGHT_PAL : FRAME_HEIGHT_NTSC;
    endfunction

endpackage

// File: rtl/vdp_super_res_mixer_bars.sv
// vdp_colour_bars: colour-bar test pattern generator.
//   clk, reset (async, active-high), de_in : pixel clock / active video
//   bar_rgb : colour for the current de_in pixel (combinational from the
//             registered pixel counter)
module vdp_colour_bars
    import custom_timings::*;
#(
    parameter int unsigned BAR_WIDTH = 90
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   de_in,
    output rgb24_t bar_rgb
);

    logic [9:0] pix_q, pix_d;
    logic [9:0] bar_idx;

    // pix_q counts the DE pixels already seen on this line, so it equals the
    // index of the pixel currently on de_in.
    always_comb begin
        pix_d = pix_q;
        if (!de_in)
            pix_d = '0;
        else if (pix_q != '1)
            pix_d = pix_q + 10'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pix_q <= '0;
        else
            pix_q <= pix_d;
    end

    always_comb begin
        bar_idx = pix_q / 10'(BAR_WIDTH);
        if (bar_idx > 10'd7)
            bar_idx = 10'd7;
        if (32'(pix_q) >= 8 * BAR_WIDTH)
            bar_rgb = '0;
        else
            bar_rgb = BAR_COLOURS[bar_idx[2:0]];
    end

endmodule

// File: rtl/vdp_super_res_mixer.sv
// vdp_super_res_mixer: final pixel selection ahead of the HDMI/DVI encoder.
//   clk, reset (async, active-high)
//   cx, cy, pal_mode       : timing counters and frame geometry
//   vdp_super              : super-res request, latched at the frame boundary
//   test_pattern_en        : force colour bars
//   de_in/hsync_in/vsync_in, legacy_*, high_res_* : phase-aligned video in
//   video_*, de_out, hsync_out, vsync_out : video out, PIPE_STAGES latency
//   super_active, frame_start : latched mode and boundary pulse
module vdp_super_res_mixer
    import custom_timings::*;
#(
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned BAR_WIDTH   = 90
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] cx,
    input  logic [9:0]  cy,
    input  logic        pal_mode,
    input  logic        vdp_super,
    input  logic        test_pattern_en,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [7:0]  legacy_r,
    input  logic [7:0]  legacy_g,
    input  logic [7:0]  legacy_b,
    input  logic [7:0]  high_res_r,
    input  logic [7:0]  high_res_g,
    input  logic [7:0]  high_res_b,
    output logic [7:0]  video_r,
    output logic [7:0]  video_g,
    output logic [7:0]  video_b,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        super_active,
    output logic        frame_start
);

    if (PIPE_STAGES < 2 || PIPE_STAGES > 4) begin : g_bad_pipe
        $error("vdp_super_res_mixer: PIPE_STAGES must be 2..4");
    end

    rgb24_t                   bar_rgb;
    rgb24_t                   sel_rgb;
    rgb24_t [PIPE_STAGES-1:0] rgb_q, rgb_d;
    logic   [PIPE_STAGES-1:0] de_q, de_d;
    logic   [PIPE_STAGES-1:0] hs_q, hs_d;
    logic   [PIPE_STAGES-1:0] vs_q, vs_d;
    logic                     super_active_q, super_active_d;
    logic                     frame_start_q, frame_start_d;
    logic                     boundary;

    vdp_colour_bars #(
        .BAR_WIDTH(BAR_WIDTH)
    ) u_bars (
        .clk    (clk),
        .reset  (reset),
        .de_in  (de_in),
        .bar_rgb(bar_rgb)
    );

    always_comb begin
        boundary = (cx == frame_width(pal_mode) - 11'd1) &&
                   (cy == frame_height(pal_mode) - 10'd1);
        super_active_d = boundary ? vdp_super : super_active_q;
        frame_start_d  = boundary;
    end

    // Selection reads super_active_q, so a boundary pixel still uses the
    // mode that was in effect before the latch.
    always_comb begin
        if (!de_in)
            sel_rgb = '0;
        else if (test_pattern_en)
            sel_rgb = bar_rgb;
        else if (super_active_q)
            sel_rgb = {high_res_r, high_res_g, high_res_b};
        else
            sel_rgb = {legacy_r, legacy_g, legacy_b};
    end

    always_comb begin
        rgb_d[0] = sel_rgb;
        de_d[0]  = de_in;
        hs_d[0]  = hsync_in;
        vs_d[0]  = vsync_in;
        for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
            rgb_d[i] = rgb_q[i-1];
            de_d[i]  = de_q[i-1];
            hs_d[i]  = hs_q[i-1];
            vs_d[i]  = vs_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q          <= '0;
            de_q           <= '0;
            hs_q           <= '0;
            vs_q           <= '0;
            super_active_q <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            rgb_q          <= rgb_d;
            de_q           <= de_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            super_active_q <= super_active_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign video_r      = rgb_q[PIPE_STAGES-1].r;
    assign video_g      = rgb_q[PIPE_STAGES-1].g;
    assign video_b      = rgb_q[PIPE_STAGES-1].b;
    assign de_out       = de_q[PIPE_STAGES-1];
    assign hsync_out    = hs_q[PIPE_STAGES-1];
    assign vsync_out    = vs_q[PIPE_STAGES-1];
    assign super_active = super_active_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vdp_super_res_mixer.sv
module tb_vdp_super_res_mixer;

    localparam int unsigned PIPE = 2;
    localparam logic [23:0] BAR_TBL [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] cx = '0;
    logic [9:0]  cy = '0;
    logic        pal_mode = 1'b0, vdp_super = 1'b0, test_pattern_en = 1'b0;
    logic        de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [7:0]  legacy_r = '0, legacy_g = '0, legacy_b = '0;
    logic [7:0]  high_res_r = '0, high_res_g = '0, high_res_b = '0;
    logic [7:0]  video_r, video_g, video_b;
    logic        de_out, hsync_out, vsync_out, super_active, frame_start;

    vdp_super_res_mixer #(
        .PIPE_STAGES(PIPE),
        .BAR_WIDTH  (90)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cx             (cx),
        .cy             (cy),
        .pal_mode       (pal_mode),
        .vdp_super      (vdp_super),
        .test_pattern_en(test_pattern_en),
        .de_in          (de_in),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .legacy_r       (legacy_r),
        .legacy_g       (legacy_g),
        .legacy_b       (legacy_b),
        .high_res_r     (high_res_r),
        .high_res_g     (high_res_g),
        .high_res_b     (high_res_b),
        .video_r        (video_r),
        .video_g        (video_g),
        .video_b        (video_b),
        .de_out         (de_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .super_active   (super_active),
        .frame_start    (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct { logic [23:0] rgb; logic de; logic hs; logic vs; } vexp_t;
    typedef struct { logic fs; logic sa; } cexp_t;

    vexp_t vq[$];
    cexp_t cq[$];
    int    checks = 0, failures = 0;
    int    fs_seen = 0, fs_model = 0;
    bit    mon_en = 1'b0;

    // Stimulus knobs, applied to the DUT inputs by step().
    logic  tp_v = 1'b0, super_v = 1'b0, pal_v = 1'b0;
    bit    rgb_rand = 1'b0, rand_super = 1'b0;

    // Reference state: mode in effect and DE run length on the current line.
    logic  m_super = 1'b0;
    int    m_run = 0;

    // Monitor: output every cycle; video has PIPE latency, control has 1.
    always @(negedge clk) begin
        if (mon_en) begin
            if (frame_start) fs_seen++;
            while (vq.size() > PIPE) begin
                vexp_t e;
                e = vq.pop_front();
                checks++;
                if ({video_r, video_g, video_b, de_out, hsync_out, vsync_out} !==
                    {e.rgb, e.de, e.hs, e.vs}) begin
                    failures++;
                    $display("FAIL video t=%0t got rgb=%06h de=%0b hs=%0b vs=%0b want rgb=%06h de=%0b hs=%0b vs=%0b",
                             $time, {video_r, video_g, video_b}, de_out, hsync_out, vsync_out,
                             e.rgb, e.de, e.hs, e.vs);
                end
            end
            while (cq.size() > 1) begin
                cexp_t c;
                c = cq.pop_front();
                checks++;
                if ({frame_start, super_active} !== {c.fs, c.sa}) begin
                    failures++;
                    $display("FAIL ctrl t=%0t got frame_start=%0b super_active=%0b want frame_start=%0b super_active=%0b",
                             $time, frame_start, super_active, c.fs, c.sa);
                end
            end
        end
    end

    // Drive one pixel now (just after a rising edge), record the expected
    // response, then advance to just after the next rising edge.
    task automatic step(input int x, input int y, input logic de, input logic hs, input logic vs);
        logic [23:0] lg, hr, er;
        logic        bnd;
        int          fw, fh;
        lg = rgb_rand ? 24'($urandom) : 24'h123456;
        hr = rgb_rand ? 24'($urandom) : 24'hABCDEF;
        cx = 11'(x);
        cy = 10'(y);
        de_in = de;
        hsync_in = hs;
        vsync_in = vs;
        pal_mode = pal_v;
        vdp_super = super_v;
        test_pattern_en = tp_v;
        {legacy_r, legacy_g, legacy_b} = lg;
        {high_res_r, high_res_g, high_res_b} = hr;
        fw = pal_v ? 864 : 858;
        fh = pal_v ? 625 : 525;
        if (!de)
            er = 24'h0;
        else if (tp_v)
            er = (m_run < 720) ? BAR_TBL[3'(m_run / 90)] : 24'h0;
        else
            er = m_super ? hr : lg;
        vq.push_back('{er, de, hs, vs});
        bnd = (x == fw - 1) && (y == fh - 1);
        if (bnd) begin
            m_super = super_v;
            fs_model++;
        end
        cq.push_back('{bnd, m_super});
        m_run = de ? ((m_run >= 1023) ? 1023 : m_run + 1) : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit check_async);
        mon_en = 1'b0;
        if (check_async) begin
            #2 reset = 1'b1;
            #1;
            checks++;
            if ({video_r, video_g, video_b, de_out, hsync_out, vsync_out, super_active, frame_start} !== 30'h0) begin
                failures++;
                $display("FAIL async_reset got rgb=%06h de=%0b hs=%0b vs=%0b sa=%0b fs=%0b want all 0",
                         {video_r, video_g, video_b}, de_out, hsync_out, vsync_out, super_active, frame_start);
            end
        end else begin
            reset = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        vq.delete();
        cq.delete();
        m_super = 1'b0;
        m_run = 0;
        for (int i = 0; i < int'(PIPE); i++) vq.push_back('{24'h0, 1'b0, 1'b0, 1'b0});
        cq.push_back('{1'b0, 1'b0});
        mon_en = 1'b1;
    endtask

    task automatic line(input int y, input int len, input int de_s, input int de_n,
                        input int hs_s, input int hs_n, input int rst_at);
        for (int x = 0; x < len; x++) begin
            if (x == rst_at) do_reset(1'b1);
            if (rand_super) super_v = 1'($urandom_range(0, 1));
            step(x, y, (x >= de_s) && (x < de_s + de_n),
                 (x >= hs_s) && (x < hs_s + hs_n), y < 3);
        end
    endtask

    // Compressed frame: a few real lines plus the two closing lines.
    task automatic frame(input int h, input int w, input int sup100, input bit rand_tp);
        int ys[6];
        ys = '{0, 1, 2, 100, h - 2, h - 1};
        for (int i = 0; i < 6; i++) begin
            if (ys[i] == 100 && sup100 >= 0) super_v = sup100[0];
            if (rand_tp) tp_v = 1'($urandom_range(0, 1));
            line(ys[i], w, 0, 720, 736, 62, -1);
        end
        tp_v = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(1'b0);

        // Legacy source, constant colours, then mid-frame super request.
        frame(525, 858, -1, 1'b0);
        frame(525, 858, 1, 1'b0);
        rgb_rand = 1'b1;
        frame(525, 858, -1, 1'b0);

        // Colour bars on two full lines, then a long saturating line.
        tp_v = 1'b1;
        line(10, 858, 0, 720, 736, 62, -1);
        line(11, 858, 0, 720, 736, 62, -1);
        line(12, 1100, 0, 1100, 2000, 0, -1);
        tp_v = 1'b0;

        // Sync/DE alignment with single-cycle hsync at arbitrary positions.
        for (int i = 0; i < 3; i++)
            line(20 + i, 858, $urandom_range(1, 200), $urandom_range(1, 600),
                 $urandom_range(0, 850), 1, -1);

        // Reset mid-line while super mode is active, then relatch.
        line(200, 858, 0, 720, 736, 62, 300);
        line(523, 858, 0, 720, 736, 62, -1);
        line(524, 858, 0, 720, 736, 62, -1);

        // Random mode toggling every cycle and random test-pattern lines.
        rand_super = 1'b1;
        frame(525, 858, -1, 1'b1);
        rand_super = 1'b0;

        // PAL geometry: the NTSC boundary point must not trigger.
        pal_v = 1'b1;
        super_v = 1'b0;
        line(0, 864, 0, 720, 736, 64, -1);
        line(524, 864, 0, 720, 736, 64, -1);
        line(623, 864, 0, 720, 736, 64, -1);
        line(624, 864, 0, 720, 736, 64, -1);
        line(0, 864, 0, 720, 736, 64, -1);

        for (int i = 0; i < int'(PIPE) + 2; i++) step(i, 1, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b0;

        checks++;
        if (fs_seen != fs_model) begin
            failures++;
            $display("FAIL frame_start_count got %0d want %0d", fs_seen, fs_model);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
